// File: rtl/prod_accumulator.sv
// prod_accumulator: sums N_TERMS unsigned 8-bit products into an ACC_W-bit
// result with a valid/ready handshake on both sides. The result is held
// until the consumer takes it.
// Optional feature macro: PROD_ACC_SAT_EN. When it is defined, overflowing
// adds saturate at 2^ACC_W-1. When it is undefined, overflowing adds wrap.
// out_ovf flags overflow in both builds.
module prod_accumulator #(
   parameter int ACC_W   = 16,
   parameter int N_TERMS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [7:0]       in_prod,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   localparam logic [7:0] CNT_LAST = 8'(N_TERMS);

   state_t           state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;

   logic [ACC_W:0]   sum_ext;
   logic [7:0]       cnt_inc;
   logic             carry;
   logic             xfer;
   logic             take;

   assign xfer = in_valid & in_ready_q;
   assign take = out_valid_q & out_ready;

   // Next-state logic: accumulate accepted products, then park in HOLD
   // until the result is taken.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum_ext = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
      carry   = sum_ext[ACC_W];
      cnt_inc = cnt_q + 8'd1;
      case (state_q)
         IDLE, ACCUM: begin
            if (xfer) begin
`ifdef PROD_ACC_SAT_EN
               acc_d = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
               acc_d = sum_ext[ACC_W-1:0];
`endif
               ovf_d   = ovf_q | carry;
               cnt_d   = cnt_inc;
               state_d = (cnt_inc == CNT_LAST) ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (take) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      // Handshake outputs are registered copies of the next state, so that
      // out_ready has no combinational path to in_ready.
      in_ready_d  = (state_d != HOLD);
      out_valid_d = (state_d == HOLD);
   end

   // State and registered outputs. The reset is synchronous.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_prod_accumulator.sv
// tb_prod_accumulator: directed vectors against three instances.
// Instance 0 uses ACC_W=16 and N_TERMS=4. Instance 1 uses ACC_W=9 and
// N_TERMS=4. Instance 2 uses ACC_W=16 and N_TERMS=1.
// Inputs are driven on the falling edge and outputs are checked there.
module tb_prod_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv [3];
   logic [7:0]  ip [3];
   logic        ordy [3];
   logic        irdy [3];
   logic        ovld [3];
   logic        oovf [3];
   logic [15:0] sum0;
   logic [8:0]  sum1;
   logic [15:0] sum2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   prod_accumulator #(.ACC_W(16), .N_TERMS(4)) u_acc0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_prod(ip[0]),
      .in_ready(irdy[0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
      .out_sum(sum0), .out_ovf(oovf[0]));

   prod_accumulator #(.ACC_W(9), .N_TERMS(4)) u_acc1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_prod(ip[1]),
      .in_ready(irdy[1]), .out_valid(ovld[1]), .out_ready(ordy[1]),
      .out_sum(sum1), .out_ovf(oovf[1]));

   prod_accumulator #(.ACC_W(16), .N_TERMS(1)) u_acc2 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_prod(ip[2]),
      .in_ready(irdy[2]), .out_valid(ovld[2]), .out_ready(ordy[2]),
      .out_sum(sum2), .out_ovf(oovf[2]));

   function automatic logic [31:0] get_sum(input int d);
      case (d)
         0:       get_sum = {16'd0, sum0};
         1:       get_sum = {23'd0, sum1};
         default: get_sum = {16'd0, sum2};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Called and returns at a falling edge. It checks in_ready, presents one
   // product, lets one rising edge pass, and then drops in_valid.
   task automatic xfer(input int d, input logic [7:0] p);
      chk("in_ready before transfer", 32'(irdy[d]), 32'd1);
      iv[d] = 1'b1;
      ip[d] = p;
      @(negedge clk);
      iv[d] = 1'b0;
      ip[d] = 8'hFF;
   endtask

   // Takes a pending result, then checks that the instance is back in IDLE.
   task automatic take(input int d);
      ordy[d] = 1'b1;
      @(negedge clk);
      ordy[d] = 1'b0;
      chk("out_valid after take", 32'(ovld[d]), 32'd0);
      chk("in_ready after take", 32'(irdy[d]), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         iv[i] = 1'b0; ip[i] = 8'd0; ordy[i] = 1'b0;
      end

      // Reset state: every instance is held in reset.
      repeat (3) @(negedge clk);
      chk("reset in_ready", 32'(irdy[0]), 32'd0);
      chk("reset out_valid", 32'(ovld[0]), 32'd0);
      chk("reset out_sum", get_sum(0), 32'd0);
      chk("reset out_ovf", 32'(oovf[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_ready after release", 32'(irdy[0]), 32'd1);

      // Four back-to-back transfers of 225 give 900. The result appears one
      // cycle after the fourth transfer.
      for (int k = 0; k < 4; k++) begin
         chk("b2b out_valid low", 32'(ovld[0]), 32'd0);
         xfer(0, 8'd225);
      end
      chk("b2b out_valid", 32'(ovld[0]), 32'd1);
      chk("b2b out_sum", get_sum(0), 32'd900);
      chk("b2b out_ovf", 32'(oovf[0]), 32'd0);
      take(0);

      // Products arrive with 2-cycle gaps. Gap cycles carry junk that must be
      // ignored, and they must not advance the count.
      xfer(0, 8'd3);
      repeat (2) @(negedge clk);
      xfer(0, 8'd10);
      repeat (2) @(negedge clk);
      xfer(0, 8'd0);
      repeat (2) @(negedge clk);
      chk("gap no early out_valid", 32'(ovld[0]), 32'd0);
      // out_ready is raised outside HOLD; it must change nothing.
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      chk("gap ordy outside HOLD", 32'(ovld[0]), 32'd0);
      xfer(0, 8'd7);
      chk("gap out_valid", 32'(ovld[0]), 32'd1);
      chk("gap out_sum", get_sum(0), 32'd20);

      // The result stays pending for 5 cycles while new inputs are offered;
      // those inputs must be ignored.
      for (int k = 0; k < 5; k++) begin
         iv[0] = 1'b1; ip[0] = 8'd50;
         @(negedge clk);
         chk("hold out_valid", 32'(ovld[0]), 32'd1);
         chk("hold out_sum", get_sum(0), 32'd20);
         chk("hold in_ready", 32'(irdy[0]), 32'd0);
      end
      iv[0] = 1'b0;
      take(0);
      // Ignored inputs must not leak into the next result.
      for (int k = 0; k < 4; k++) xfer(0, 8'd1);
      chk("post-hold out_sum", get_sum(0), 32'd4);
      take(0);

      // With ACC_W=9, four transfers of 225 (900) overflow.
      ordy[1] = 1'b1;
      for (int k = 0; k < 4; k++) xfer(1, 8'd225);
      chk("ovf out_valid", 32'(ovld[1]), 32'd1);
      chk("ovf out_ovf", 32'(oovf[1]), 32'd1);
`ifdef PROD_ACC_SAT_EN
      chk("ovf out_sum", get_sum(1), 32'd511);
`else
      chk("ovf out_sum", get_sum(1), 32'd388);
`endif
      @(negedge clk);
      ordy[1] = 1'b0;
      chk("ovf cleared after take", 32'(oovf[1]), 32'd0);

      // Reset after 2 of 4 transfers discards the partial sum.
      xfer(0, 8'd9);
      xfer(0, 8'd9);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid-reset in_ready", 32'(irdy[0]), 32'd0);
      chk("mid-reset out_valid", 32'(ovld[0]), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("post-reset no out_valid", 32'(ovld[0]), 32'd0);
         xfer(0, 8'd1);
      end
      chk("post-reset out_valid", 32'(ovld[0]), 32'd1);
      chk("post-reset out_sum", get_sum(0), 32'd4);
      take(0);

      // With N_TERMS=1, a single transfer completes the result.
      chk("n1 out_valid low", 32'(ovld[2]), 32'd0);
      xfer(2, 8'd169);
      chk("n1 out_valid", 32'(ovld[2]), 32'd1);
      chk("n1 out_sum", get_sum(2), 32'd169);
      chk("n1 out_ovf", 32'(oovf[2]), 32'd0);
      take(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/prod_accumulator.md
PROD_ACCUMULATOR -- requirements
Module: prod_accumulator

Interface
REQ-001 The block SHALL have parameter ACC_W, default 16, giving the accumulator and result width; legal range 8..32.
REQ-002 The block SHALL have parameter N_TERMS, default 4, giving the number of products summed per result; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, indicating that in_prod is valid.
REQ-006 The block SHALL have port in_prod, input, 8, an unsigned product from the upstream 4x4 multiplier.
REQ-007 The block SHALL have port in_ready, output, 1, indicating that the block accepts a product this cycle.
REQ-008 The block SHALL have port out_valid, output, 1, indicating that out_sum and out_ovf are valid.
REQ-009 The block SHALL have port out_ready, input, 1, indicating that the consumer takes the result this cycle.
REQ-010 The block SHALL have port out_sum, output, ACC_W, the accumulated result.
REQ-011 The block SHALL have port out_ovf, output, 1, flagging overflow in the current result.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, ACCUM and HOLD.
REQ-013 An input transfer SHALL occur on any cycle with in_valid=1 and in_ready=1; in_prod SHALL be ignored otherwise.
REQ-014 in_ready SHALL be 1 in IDLE and ACCUM and 0 in HOLD, registered from state with no combinational path from out_ready.
REQ-015 IDLE SHALL behave as follows: acc=0, cnt=0, ovf=0; a transfer adds in_prod, increments cnt and moves to ACCUM, or directly to HOLD if N_TERMS=1.
REQ-016 ACCUM SHALL behave as follows: each transfer adds zero-extended in_prod to acc and increments cnt; the transfer making cnt=N_TERMS moves to HOLD; cycles without in_valid leave state unchanged.
REQ-017 out_valid SHALL be 1 exactly while in HOLD, starting the cycle after the N_TERMS-th transfer (latency 1 cycle).
REQ-018 In HOLD, out_sum and out_ovf SHALL be held stable until out_valid=1 and out_ready=1.
REQ-019 On the out_valid=1 and out_ready=1 cycle, the block SHALL go to IDLE and clear acc, cnt and ovf; in_ready becomes 1 the next cycle.
REQ-020 out_ready asserted outside HOLD SHALL have no effect.
REQ-021 Overflow SHALL be detected when acc + in_prod exceeds 2^ACC_W-1; ovf is sticky until the result is taken or reset.
REQ-022 cnt SHALL be 8 bits wide and SHALL never exceed N_TERMS.

Reset
REQ-023 While rst_n=0 at a clk edge, the block SHALL set state=IDLE, acc=0, cnt=0, ovf=0.
REQ-024 Reset values SHALL be: in_ready=0 during reset and 1 the cycle after release, out_valid=0, out_sum=0, out_ovf=0.
REQ-025 Reset in ACCUM or HOLD SHALL discard the partial or pending result with no output transfer.

Configuration
REQ-026 When macro PROD_ACC_SAT_EN is defined, an overflowing add SHALL set acc to 2^ACC_W-1, and acc SHALL remain there for later adds.
REQ-027 When PROD_ACC_SAT_EN is undefined, an overflowing add SHALL wrap modulo 2^ACC_W.
REQ-028 out_ovf SHALL be set on overflow in both configurations.

Verification
REQ-029 The bench SHALL cover: ACC_W=16, N_TERMS=4, four transfers of 225 back-to-back, out_ready=1 -> out_valid one cycle after the 4th transfer, out_sum=900, out_ovf=0.
REQ-030 The bench SHALL cover: products 3, 10, 0, 7 with in_valid gaps of 2 cycles -> out_sum=20, and no count advance on gap cycles.
REQ-031 The bench SHALL cover: result pending with out_ready=0 for 5 cycles -> out_sum stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE and in_ready=1 the next cycle.
REQ-032 The bench SHALL cover: ACC_W=9, four transfers of 225 -> out_ovf=1, out_sum=388 without PROD_ACC_SAT_EN and 511 with it.
REQ-033 The bench SHALL cover: rst_n=0 after 2 of 4 transfers, then a fresh four transfers of 1 -> out_sum=4, with no earlier out_valid.
REQ-034 The bench SHALL cover: N_TERMS=1, transfer of 169 -> out_valid next cycle, out_sum=169.
